// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable
//   Run-time loadable instruction memory. A program image is streamed in one
//   cell at a time through the load port. Once loaded, the memory serves
//   registered big-endian word fetches, which hold while stalled.
//
//   Load port : load_start, load_valid, load_last, load_byte -> load_ready,
//               load_done (1-cycle pulse), load_overflow (sticky), load_len
//   Fetch port: fetch_en, stall, addr -> instruction, instr_valid,
//               misaligned, out_of_range (all registered)
//   Status    : mem_ready (state is READY)
module instr_mem_loadable #(
  parameter int                  WORD_LEN       = 32,
  parameter int                  MEM_CELL_SIZE  = 8,
  parameter int                  INSTR_MEM_SIZE = 1024,
  parameter logic [WORD_LEN-1:0] NOP_WORD       = 32'h00000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_start,
  input  logic                              load_valid,
  input  logic                              load_last,
  input  logic [MEM_CELL_SIZE-1:0]          load_byte,
  output logic                              load_ready,
  output logic                              load_done,
  output logic                              load_overflow,
  output logic [$clog2(INSTR_MEM_SIZE):0]   load_len,
  input  logic                              fetch_en,
  input  logic                              stall,
  input  logic [WORD_LEN-1:0]               addr,
  output logic [WORD_LEN-1:0]               instruction,
  output logic                              instr_valid,
  output logic                              misaligned,
  output logic                              out_of_range,
  output logic                              mem_ready
);

  localparam int BYTES = WORD_LEN / MEM_CELL_SIZE;
  localparam int AW    = $clog2(INSTR_MEM_SIZE);
  localparam int LW    = AW + 1;
  localparam int OW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LW-1:0] MEM_SIZE_L = LW'(INSTR_MEM_SIZE);
  localparam logic [LW-1:0] LAST_PTR_L = LW'(INSTR_MEM_SIZE - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic [LW-1:0]            ptr_r, ptr_s;
  logic [LW-1:0]            len_r, len_s;
  logic                     ovf_r, ovf_s;
  logic                     done_r, done_s;
  logic                     wr_en_s;
  logic                     load_ready_s;

  logic [WORD_LEN-1:0]      instr_r, instr_s;
  logic                     valid_r, valid_s;
  logic                     mis_r, mis_s;
  logic                     oor_r, oor_s;
  logic [WORD_LEN:0]        end_addr_s;
  logic [WORD_LEN:0]        len_ext_s;
  logic [WORD_LEN-1:0]      rd_word_s;

  // Program storage; deliberately not reset, load_len gates visibility.
  logic [MEM_CELL_SIZE-1:0] mem_r [INSTR_MEM_SIZE];

  assign load_ready_s  = (state_r == LOADING) && (ptr_r < MEM_SIZE_L);
  assign load_ready    = load_ready_s;
  assign load_done     = done_r;
  assign load_overflow = ovf_r;
  assign load_len      = len_r;
  assign mem_ready     = (state_r == READY);
  assign instruction   = instr_r;
  assign instr_valid   = valid_r;
  assign misaligned    = mis_r;
  assign out_of_range  = oor_r;

  // Load state machine: next state, pointer, length and status.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    len_s   = len_r;
    ovf_s   = ovf_r;
    done_s  = 1'b0;
    wr_en_s = 1'b0;
    case (state_r)
      EMPTY, READY: begin
        if (load_start) begin
          state_s = LOADING;
          ptr_s   = '0;
          len_s   = '0;
          ovf_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      LOADING: begin
        if (load_start) begin
          // Restart wins over any byte offered in the same cycle.
          ptr_s = '0;
          len_s = '0;
        end else if (load_valid && load_ready_s) begin
          wr_en_s = 1'b1;
          ptr_s   = ptr_r + LW'(1);
          if (load_last) begin
            state_s = READY;
            len_s   = ptr_r + LW'(1);
            done_s  = 1'b1;
          end else if (ptr_r == LAST_PTR_L) begin
            // Memory full with no end marker: close the image as overflowed.
            state_s = READY;
            len_s   = MEM_SIZE_L;
            ovf_s   = 1'b1;
            done_s  = 1'b1;
          end else begin
            state_s = LOADING;
          end
        end else if (ptr_r >= MEM_SIZE_L) begin
          // Pointer cannot normally rest here; recover to a consistent READY.
          state_s = READY;
          len_s   = MEM_SIZE_L;
          ovf_s   = 1'b1;
          done_s  = 1'b1;
        end else begin
          state_s = LOADING;
        end
      end
      default: begin
        state_s = EMPTY;
        ptr_s   = '0;
        len_s   = '0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  // Memory write port, fed by the load handshake.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[ptr_r[AW-1:0]] <= load_byte;
    end
  end

  // Big-endian word assembly: lowest address lands in the top cell.
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < BYTES; i++) begin
      logic [AW-1:0] idx_v;
      idx_v = addr[AW-1:0] + AW'(i);
      rd_word_s[WORD_LEN-1-i*MEM_CELL_SIZE -: MEM_CELL_SIZE] = mem_r[idx_v];
    end
  end

  // One extra bit keeps the end-of-word compare free of wrap-around.
  assign end_addr_s = {1'b0, addr} + (WORD_LEN+1)'(BYTES);
  assign len_ext_s  = {{(WORD_LEN+1-LW){1'b0}}, len_r};

  // Fetch result selection; stall holds, then invalid, misaligned, range.
  always_comb begin
    instr_s = instr_r;
    valid_s = valid_r;
    mis_s   = mis_r;
    oor_s   = oor_r;
    if (stall) begin
      instr_s = instr_r;
      valid_s = valid_r;
      mis_s   = mis_r;
      oor_s   = oor_r;
    end else if ((state_r != READY) || !fetch_en || load_start) begin
      instr_s = NOP_WORD;
      valid_s = 1'b0;
      mis_s   = 1'b0;
      oor_s   = 1'b0;
    end else if (addr[OW-1:0] != '0) begin
      instr_s = NOP_WORD;
      valid_s = 1'b1;
      mis_s   = 1'b1;
      oor_s   = 1'b0;
    end else if (end_addr_s > len_ext_s) begin
      instr_s = NOP_WORD;
      valid_s = 1'b1;
      mis_s   = 1'b0;
      oor_s   = 1'b1;
    end else begin
      instr_s = rd_word_s;
      valid_s = 1'b1;
      mis_s   = 1'b0;
      oor_s   = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      ptr_r   <= '0;
      len_r   <= '0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      instr_r <= NOP_WORD;
      valid_r <= 1'b0;
      mis_r   <= 1'b0;
      oor_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      len_r   <= len_s;
      ovf_r   <= ovf_s;
      done_r  <= done_s;
      instr_r <= instr_s;
      valid_r <= valid_s;
      mis_r   <= mis_s;
      oor_r   <= oor_s;
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: a default-size instance for the
// load/fetch/stall/reset scenarios and a 16-cell instance for overflow.
module tb_instr_mem_loadable;

  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance signals
  logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_ready, load_done, load_overflow;
  logic [10:0] load_len;
  logic        fetch_en = 1'b0, stall = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid, misaligned, out_of_range, mem_ready;

  // 16-cell instance signals
  logic        load_start_b = 1'b0, load_valid_b = 1'b0, load_last_b = 1'b0;
  logic [7:0]  load_byte_b = 8'h00;
  logic        load_ready_b, load_done_b, load_overflow_b;
  logic [4:0]  load_len_b;
  logic        fetch_en_b = 1'b0, stall_b = 1'b0;
  logic [31:0] addr_b = 32'h0;
  logic [31:0] instruction_b;
  logic        instr_valid_b, misaligned_b, out_of_range_b, mem_ready_b;

  instr_mem_loadable dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_byte(load_byte), .load_ready(load_ready), .load_done(load_done),
    .load_overflow(load_overflow), .load_len(load_len),
    .fetch_en(fetch_en), .stall(stall), .addr(addr),
    .instruction(instruction), .instr_valid(instr_valid),
    .misaligned(misaligned), .out_of_range(out_of_range), .mem_ready(mem_ready)
  );

  instr_mem_loadable #(.INSTR_MEM_SIZE(16)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start_b), .load_valid(load_valid_b), .load_last(load_last_b),
    .load_byte(load_byte_b), .load_ready(load_ready_b), .load_done(load_done_b),
    .load_overflow(load_overflow_b), .load_len(load_len_b),
    .fetch_en(fetch_en_b), .stall(stall_b), .addr(addr_b),
    .instruction(instruction_b), .instr_valid(instr_valid_b),
    .misaligned(misaligned_b), .out_of_range(out_of_range_b), .mem_ready(mem_ready_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic        v;
    logic        m;
    logic        o;
  } fetch_t;

  fetch_t      sb_q[$];
  fetch_t      last_exp = '{NOP, 1'b0, 1'b0, 1'b0};
  logic [7:0]  model_mem [1024];
  int          model_len = 0;
  bit          model_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic fetch_t model_fetch(input logic [31:0] a);
    fetch_t r;
    r = '{NOP, 1'b0, 1'b0, 1'b0};
    if (!model_ready) r = '{NOP, 1'b0, 1'b0, 1'b0};
    else if (a[1:0] != 2'b00) r = '{NOP, 1'b1, 1'b1, 1'b0};
    else if ({1'b0, a} + 33'd4 > 33'(model_len)) r = '{NOP, 1'b1, 1'b0, 1'b1};
    else r = '{{model_mem[a[9:0]], model_mem[a[9:0] + 10'd1],
                model_mem[a[9:0] + 10'd2], model_mem[a[9:0] + 10'd3]},
               1'b1, 1'b0, 1'b0};
    return r;
  endfunction

  // Drive one fetch cycle, push its expected result, then pop and compare.
  task automatic fetch(input string name, input logic [31:0] a, input bit en, input bit st);
    fetch_t e, got;
    addr = a; fetch_en = en; stall = st;
    if (st) e = last_exp;
    else if (!en) e = '{NOP, 1'b0, 1'b0, 1'b0};
    else e = model_fetch(a);
    last_exp = e;
    sb_q.push_back(e);
    step();
    e = sb_q.pop_front();
    got = '{instruction, instr_valid, misaligned, out_of_range};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got instr=%h v=%b mis=%b oor=%b, expected instr=%h v=%b mis=%b oor=%b",
               name, got.instr, got.v, got.m, got.o, e.instr, e.v, e.m, e.o);
    end
    fetch_en = 1'b0; stall = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    model_ready = 1'b0;
    model_len = 0;
    last_exp = '{NOP, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      load_valid = 1'b1; load_byte = b[i]; load_last = (i == b.size() - 1);
      checks++;
      if (load_ready !== 1'b1) begin
        errors++; $display("FAIL load_ready byte %0d: got %b expected 1", i, load_ready);
      end
      step();
      model_mem[i] = b[i];
    end
    load_valid = 1'b0; load_last = 1'b0;
    model_len = b.size();
    model_ready = 1'b1;
    checks++;
    if (load_done !== 1'b1 || load_len !== 11'(b.size()) || mem_ready !== 1'b1 || load_overflow !== 1'b0) begin
      errors++;
      $display("FAIL load_complete: got done=%b len=%0d ready=%b ovf=%b expected 1 %0d 1 0",
               load_done, load_len, mem_ready, load_overflow, b.size());
    end
    step();
    checks++;
    if (load_done !== 1'b0) begin
      errors++; $display("FAIL load_done_pulse: got %b expected 0", load_done);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (instruction !== NOP || instr_valid !== 1'b0 || misaligned !== 1'b0 || out_of_range !== 1'b0 ||
        load_ready !== 1'b0 || load_done !== 1'b0 || load_overflow !== 1'b0 ||
        load_len !== 11'd0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got instr=%h v=%b len=%0d ready=%b ldy=%b, expected all zero",
               instruction, instr_valid, load_len, mem_ready, load_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    fetch("fetch_when_empty", 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_load_and_fetch();
    start_load();
    send_bytes('{8'h80, 8'h20, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00});
    fetch("fetch_addr0", 32'h0, 1'b1, 1'b0);
    if (instruction !== 32'h8020000A) begin
      checks++; errors++; $display("FAIL word0_const: got %h expected 8020000a", instruction);
    end
    fetch("fetch_addr4", 32'h4, 1'b1, 1'b0);
    fetch("fetch_disabled", 32'h4, 1'b0, 1'b0);
  endtask

  task automatic test_bad_addresses();
    fetch("oor_addr8", 32'h8, 1'b1, 1'b0);
    fetch("misaligned_addr2", 32'h2, 1'b1, 1'b0);
    fetch("no_alias_high", 32'h00010000, 1'b1, 1'b0);
    fetch("oor_wrap_top", 32'hFFFFFFFC, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    fetch("stall_pre", 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) fetch("stall_hold", 32'h4, 1'b1, 1'b1);
    fetch("stall_release", 32'h4, 1'b1, 1'b0);
    fetch("b2b_0", 32'h0, 1'b1, 1'b0);
    fetch("b2b_4", 32'h4, 1'b1, 1'b0);
    fetch("b2b_0_again", 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_restart();
    // load_start in READY with a pending fetch drops validity next cycle
    addr = 32'h0; fetch_en = 1'b1; load_start = 1'b1;
    step();
    load_start = 1'b0; fetch_en = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_ready !== 1'b0 || load_len !== 11'd0) begin
      errors++;
      $display("FAIL ready_invalidate: got v=%b ready=%b len=%0d expected 0 0 0",
               instr_valid, mem_ready, load_len);
    end
    model_ready = 1'b0; model_len = 0;
    // two bytes, then a start coinciding with a 0xFF byte
    load_valid = 1'b1; load_byte = 8'hAA; step();
    load_byte = 8'hBB; step();
    load_start = 1'b1; load_byte = 8'hFF; step();
    load_start = 1'b0; load_valid = 1'b0;
    last_exp = '{NOP, 1'b0, 1'b0, 1'b0};
    send_bytes('{8'h11, 8'h22, 8'h33, 8'h44});
    fetch("restart_word0", 32'h0, 1'b1, 1'b0);
    fetch("restart_oor4", 32'h4, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    start_load();
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin load_byte = 8'(i + 8'h50); step(); end
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (instruction !== NOP || instr_valid !== 1'b0 || load_ready !== 1'b0 ||
        load_len !== 11'd0 || mem_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got instr=%h v=%b ldy=%b len=%0d ready=%b expected nop/0",
               instruction, instr_valid, load_ready, load_len, mem_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    model_ready = 1'b0; model_len = 0;
    last_exp = '{NOP, 1'b0, 1'b0, 1'b0};
    fetch("fetch_after_reset", 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow_small();
    logic [31:0] exp_w;
    load_start_b = 1'b1; step(); load_start_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      load_valid_b = 1'b1; load_byte_b = 8'(8'h30 + i);
      checks++;
      if (load_ready_b !== (i < 16)) begin
        errors++; $display("FAIL small_ready byte %0d: got %b expected %b", i, load_ready_b, (i < 16));
      end
      step();
      if (i == 15) begin
        checks++;
        if (load_done_b !== 1'b1 || load_overflow_b !== 1'b1 || load_len_b !== 5'd16 || mem_ready_b !== 1'b1) begin
          errors++;
          $display("FAIL small_overflow: got done=%b ovf=%b len=%0d ready=%b expected 1 1 16 1",
                   load_done_b, load_overflow_b, load_len_b, mem_ready_b);
        end
      end
    end
    load_valid_b = 1'b0;
    checks++;
    if (load_done_b !== 1'b0 || load_overflow_b !== 1'b1 || load_len_b !== 5'd16) begin
      errors++;
      $display("FAIL small_after: got done=%b ovf=%b len=%0d expected 0 1 16",
               load_done_b, load_overflow_b, load_len_b);
    end
    addr_b = 32'd12; fetch_en_b = 1'b1; step(); fetch_en_b = 1'b0;
    exp_w = {8'h3C, 8'h3D, 8'h3E, 8'h3F};
    checks++;
    if (instruction_b !== exp_w || instr_valid_b !== 1'b1 || out_of_range_b !== 1'b0) begin
      errors++;
      $display("FAIL small_fetch12: got %h v=%b oor=%b expected %h 1 0",
               instruction_b, instr_valid_b, out_of_range_b, exp_w);
    end
    addr_b = 32'd16; fetch_en_b = 1'b1; step(); fetch_en_b = 1'b0;
    checks++;
    if (instruction_b !== NOP || instr_valid_b !== 1'b1 || out_of_range_b !== 1'b1) begin
      errors++;
      $display("FAIL small_fetch16: got %h v=%b oor=%b expected 0 1 1",
               instruction_b, instr_valid_b, out_of_range_b);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_fetch();
    test_bad_addresses();
    test_stall();
    test_restart();
    test_overflow_small();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Next-generation instruction memory: byte-cell, big-endian, word-fetch store, parametrised in word width and depth.
- Unlike a fixed-image ROM, the program is streamed in at run time through a byte-wide load port, under a load state machine.
- Fetch is registered (1-cycle latency) with stall hold, and flags misaligned and out-of-range accesses.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- WORD_LEN, 32, fetch word width in bits; must be a multiple of MEM_CELL_SIZE.
- MEM_CELL_SIZE, 8, bits per memory cell (byte).
- INSTR_MEM_SIZE, 1024, memory depth in cells; power of two.
- NOP_WORD, 32'h00000000, word returned on invalid or out-of-range fetch.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  begin (or restart) a program load.
- load_valid  in  1  load_byte is valid this cycle.
- load_last  in  1  qualifies the final byte of the image.
- load_byte  in  MEM_CELL_SIZE  program byte, in big-endian order.
- load_ready  out  1  block accepts a byte this cycle.
- load_done  out  1  one-cycle pulse when a load completes.
- load_overflow  out  1  sticky: image exceeded INSTR_MEM_SIZE.
- load_len  out  $clog2(INSTR_MEM_SIZE)+1  number of bytes loaded.
- fetch_en  in  1  fetch request.
- stall  in  1  hold the current fetch output.
- addr  in  WORD_LEN  byte address, from the PC.
- instruction  out  WORD_LEN  fetched word, registered.
- instr_valid  out  1  instruction is a valid fetch result.
- misaligned  out  1  registered: last fetch address was not word-aligned.
- out_of_range  out  1  registered: last fetch extended past load_len.
- mem_ready  out  1  state is READY.

Behaviour:
- States are EMPTY, LOADING and READY.
- Reset (async, rst_n=0):
  - state EMPTY; write pointer 0; load_len 0; load_overflow 0.
  - instruction = NOP_WORD; every other output 0.
  - Memory contents are not cleared; unloaded cells are unreachable because of the load_len check.
- EMPTY or READY, load_start=1 → LOADING next cycle: pointer=0, load_len=0, load_overflow=0.
- LOADING:
  - load_ready = 1 while pointer < INSTR_MEM_SIZE.
  - Handshake is load_valid & load_ready: write load_byte to mem[pointer], then pointer+1.
  - Handshake with load_last=1 → READY; load_len = pointer+1; load_done pulses for 1 cycle in the same edge that updates load_len.
  - Pointer reaches INSTR_MEM_SIZE without load_last → READY; load_len = INSTR_MEM_SIZE; load_overflow=1; load_done pulses.
  - Further bytes are ignored (load_ready=0 outside LOADING).
- load_start during LOADING restarts the load: pointer=0, load_len=0.
- load_start together with load_valid: load_start wins and the byte is discarded.
- Fetch, evaluated each rising edge:
  - stall=1: instruction, instr_valid, misaligned and out_of_range all hold. stall has priority over fetch_en.
  - State ≠ READY, or fetch_en=0 (no stall): instr_valid=0; instruction=NOP_WORD; both flags 0.
  - READY & fetch_en & !stall: instr_valid=1 next cycle, with the first matching case below.
    - addr[1:0]≠0 → instruction=NOP_WORD, misaligned=1.
    - addr+WORD_LEN/8 > load_len (compare at full width, no wrap) → NOP_WORD, out_of_range=1.
    - Otherwise → instruction = {mem[addr], mem[addr+1], …, mem[addr+WORD_LEN/8-1]}, most-significant byte at the lowest address; both flags 0.
  - Address bits above the memory index never alias; such addresses are always out_of_range.
- Reset during LOADING discards the partial image (load_len=0, state EMPTY).
- load_start in READY invalidates fetches: instr_valid=0 from the next cycle.

Test Plan:
- Load 80 20 00 0A 04 40 08 00 (load_last on the 8th byte) → load_done pulse, load_len=8, mem_ready=1. Fetch addr 0 → next cycle instruction=32'h8020000A, instr_valid=1; addr 4 → 32'h04400800.
- After that load, fetch addr 8 → NOP_WORD, out_of_range=1. Fetch addr 2 → NOP_WORD, misaligned=1. Fetch addr 32'h00010000 → out_of_range=1, no alias.
- Fetch addr 0, then stall=1 for 3 cycles while addr changes to 4 → instruction stays 32'h8020000A, instr_valid=1. Release stall → 32'h04400800.
- INSTR_MEM_SIZE=16: stream 20 bytes with no load_last → load_ready drops after byte 16, load_overflow=1, load_len=16, READY. Fetch addr 12 returns bytes 12–15.
- Assert rst_n=0 after 3 loaded bytes → all outputs 0/NOP asynchronously, state EMPTY. Fetch after release → instr_valid=0.
- Assert load_start and load_valid (byte 8'hFF) in the same cycle during LOADING → byte discarded, pointer=0. The next byte is written to mem[0].
